// File: rtl/eep_pkg.sv
// ============================================================================
// Module   : eep_pkg
// Purpose  : Shared types and default constants for the EEPROM responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eep_pkg;

   localparam int              DEF_DATA_W   = 12;
   localparam int              DEF_ADDR_W   = 4;
   localparam int              DEF_TM_W     = 14;
   localparam logic [13:0]     DEF_PROG_CYC = 14'h2EE0;
   localparam int              DEF_PMP_TO   = 4;
   localparam logic [11:0]     ERASE_VAL    = 12'hFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      READ     = 2'd1,
      WAIT_PMP = 2'd2,
      PROG     = 2'd3
   } eep_state_t;

endpackage

`default_nettype wire

// File: rtl/eep_prog_timer.sv
// ============================================================================
// Module   : eep_prog_timer
// Purpose  : Saturating programming timer with a registered PROG_CYC match.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eep_prog_timer #(
   parameter int                TM_W     = eep_pkg::DEF_TM_W,
   parameter logic [TM_W-1:0]   PROG_CYC = eep_pkg::DEF_PROG_CYC
) (
   input  logic clk,
   input  logic clr_tm,
   input  logic clr,
   input  logic inc,
   output logic eq
);

   logic [TM_W-1:0] r_cnt;
   logic [TM_W-1:0] w_nxt;
   logic            r_eq;

   always_comb begin
      w_nxt = r_cnt;
      if (clr)
         w_nxt = '0;
      else if (inc && (r_cnt != {TM_W{1'b1}}))
         w_nxt = r_cnt + TM_W'(1);
   end

   // eq is registered from the next count so it is high exactly while cnt == PROG_CYC
   always_ff @(posedge clk or posedge clr_tm) begin
      if (clr_tm) begin
         r_cnt <= '0;
         r_eq  <= 1'b0;
      end else begin
         r_cnt <= w_nxt;
         r_eq  <= (w_nxt == PROG_CYC);
      end
   end

   assign eq = r_eq;

endmodule

`default_nettype wire

// File: rtl/eep_resp.sv
// ============================================================================
// Module   : eep_resp
// Purpose  : EEPROM-side responder: captures writes, commits after the full
//            pump time, serves reads. EEP_RESP_WEAR_CNT_EN adds wear counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eep_resp
   import eep_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                TM_W     = DEF_TM_W,
   parameter logic [TM_W-1:0]   PROG_CYC = DEF_PROG_CYC,
   parameter int                PMP_TO   = DEF_PMP_TO
) (
   input  logic              clk,
   input  logic              clr_tm,
   input  logic              eep_cs_n,
   input  logic              eep_r_w_n,
   input  logic [ADDR_W-1:0] eep_addr,
   input  logic              chrg_pmp_en,
   inout  wire  [DATA_W-1:0] eep_bus,
   output logic              eep_busy,
   output logic              prog_done,
   output logic              prog_err
`ifdef EEP_RESP_WEAR_CNT_EN
   ,output logic             wear_lim
`endif
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam int              PTO_W    = $clog2(PMP_TO + 1);
   localparam logic [PTO_W-1:0] PTO_LAST = PTO_W'(PMP_TO - 1);

   eep_state_t        r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [DATA_W-1:0] r_wbuf;
   logic [ADDR_W-1:0] r_abuf;
   logic [DATA_W-1:0] r_rdata;
   logic [PTO_W-1:0]  r_pto;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic w_tm_clr;
   logic w_tm_inc;
   logic w_tm_eq;
   logic w_commit;
   logic w_drv;

   assign w_tm_clr = (r_state == IDLE) && !eep_cs_n && !eep_r_w_n;
   assign w_tm_inc = ((r_state == WAIT_PMP) || (r_state == PROG)) && chrg_pmp_en;
   assign w_commit = (r_state == PROG) && chrg_pmp_en && w_tm_eq;
   assign w_drv    = (r_state == READ) && !eep_cs_n && eep_r_w_n;

   eep_prog_timer #(
      .TM_W     (TM_W),
      .PROG_CYC (PROG_CYC)
   ) u_timer (
      .clk    (clk),
      .clr_tm (clr_tm),
      .clr    (w_tm_clr),
      .inc    (w_tm_inc),
      .eq     (w_tm_eq)
   );

   always_ff @(posedge clk or posedge clr_tm) begin
      if (clr_tm) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_wbuf  <= '0;
         r_abuf  <= '0;
         r_rdata <= '1;
         r_pto   <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!eep_cs_n) begin
                  if (eep_r_w_n) begin
                     r_rdata <= r_mem[eep_addr];
                     r_state <= READ;
                  end else begin
                     r_wbuf  <= eep_bus;
                     r_abuf  <= eep_addr;
                     r_err   <= 1'b0;
                     r_pto   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= WAIT_PMP;
                  end
               end
            end
            READ: begin
               if (eep_cs_n)
                  r_state <= IDLE;
            end
            WAIT_PMP: begin
               if (chrg_pmp_en) begin
                  r_state <= PROG;
               end else if (r_pto == PTO_LAST) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_pto <= r_pto + PTO_W'(1);
               end
            end
            PROG: begin
               if (!chrg_pmp_en) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_commit) begin
                  r_mem[r_abuf] <= r_wbuf;
                  r_done        <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign eep_bus   = w_drv ? r_rdata : {DATA_W{1'bz}};
   assign eep_busy  = r_busy;
   assign prog_done = r_done;
   assign prog_err  = r_err;

`ifdef EEP_RESP_WEAR_CNT_EN
   logic [7:0] r_wear [DEPTH];
   logic       w_lim;

   // Counters saturate; the commit itself is never blocked by wear
   always_ff @(posedge clk or posedge clr_tm) begin
      if (clr_tm) begin
         for (int i = 0; i < DEPTH; i++)
            r_wear[i] <= '0;
      end else if (w_commit && (r_wear[r_abuf] != 8'hFF)) begin
         r_wear[r_abuf] <= r_wear[r_abuf] + 8'd1;
      end
   end

   always_comb begin
      w_lim = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (r_wear[i] == 8'hFF)
            w_lim = 1'b1;
   end

   assign wear_lim = w_lim;
`endif

endmodule

`default_nettype wire
